// File: rtl/weight_bram_reader_if.sv
// Bundles the BRAM read port and the weight stream toward the neuron MAC.
// The reader drives the BRAM address/enable and the weight word; the other side drives read data and ready.
interface weight_bram_reader_if #(
    parameter int AW = 5,
    parameter int DW = 16
);
    logic [AW-1:0] BRAM_ADDR;
    logic          BRAM_EN;
    logic          BRAM_WE;
    logic [DW-1:0] BRAM_DO;
    logic [DW-1:0] W_DATA;
    logic [AW-1:0] W_IDX;
    logic          W_LAST;
    logic          W_VALID;
    logic          W_READY;

    modport master (
        output BRAM_ADDR, BRAM_EN, BRAM_WE, W_DATA, W_IDX, W_LAST, W_VALID,
        input  BRAM_DO, W_READY
    );

    modport slave (
        input  BRAM_ADDR, BRAM_EN, BRAM_WE, W_DATA, W_IDX, W_LAST, W_VALID,
        output BRAM_DO, W_READY
    );
endinterface

// File: rtl/weight_bram_reader.sv
// Walks weight BRAM addresses 0..DEPTH-1 on START and streams {weight, index} to the MAC.
// A 2-entry skid FIFO plus a credit check on issue absorbs arbitrary backpressure without loss.
module weight_bram_reader #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic START,
    output logic BUSY,
    output logic DONE,
    weight_bram_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
    } entry_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic          en_q;
    logic          inflight_q;
    logic          done_q;
    entry_t        fifo_q [2];
    logic          rd_ptr_q, wr_ptr_q;
    logic [1:0]    count_q;

    logic          push, pop, issue, done_d;
    logic [1:0]    count_next;
    logic [AW-1:0] issue_addr;
    entry_t        head;
    logic          head_last;

    assign push       = inflight_q;
    assign pop        = (count_q != 2'd0) && bus.W_READY;
    assign count_next = count_q + 2'(push) - 2'(pop);
    assign head       = fifo_q[rd_ptr_q];
    assign head_last  = (head.idx == LAST_ADDR);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        state_d    = state_q;
        issue      = 1'b0;
        issue_addr = addr_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    issue      = 1'b1;
                    issue_addr = '0;
                    state_d    = (DEPTH == 1) ? DRAIN : RUN;
                end
            end
            RUN: begin
                // Credit: the word this read returns must still fit after this edge's push/pop.
                if (count_next <= 2'd1) begin
                    issue      = 1'b1;
                    issue_addr = addr_q + AW'(1);
                    if (issue_addr == LAST_ADDR) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state and control use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q     <= '0;
            en_q       <= 1'b0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            done_q     <= 1'b0;
        end else begin
            en_q       <= issue;
            inflight_q <= issue;
            done_q     <= done_d;
            count_q    <= count_next;
            if (issue) addr_q   <= issue_addr;
            if (push)  wr_ptr_q <= ~wr_ptr_q;
            if (pop)   rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // NOTE: FIFO storage is not reset; outputs are masked by valid, so stale contents never leak.
    always_ff @(posedge CLK) begin
        if (!RST && push) fifo_q[wr_ptr_q] <= '{data: bus.BRAM_DO, idx: addr_q};
    end

    assign BUSY          = (state_q != IDLE);
    assign DONE          = done_q;
    assign bus.BRAM_ADDR = addr_q;
    assign bus.BRAM_EN   = en_q;
    assign bus.BRAM_WE   = 1'b0;
    assign bus.W_VALID   = (count_q != 2'd0);
    assign bus.W_DATA    = bus.W_VALID ? head.data : '0;
    assign bus.W_IDX     = bus.W_VALID ? head.idx  : '0;
    assign bus.W_LAST    = bus.W_VALID && head_last;
endmodule

// File: tb/tb_weight_bram_reader.sv
// Scoreboard bench for weight_bram_reader: full rate, stall, random backpressure, START filtering,
// mid-sequence reset, and a small DEPTH=5 instance.
module tb_weight_bram_reader;
    localparam int DEPTH   = 28;
    localparam int AW      = 5;
    localparam int DW      = 16;
    localparam int S_DEPTH = 5;
    localparam int S_AW    = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
        logic          last;
    } exp_t;

    logic CLK = 1'b0;
    logic RST, START, start_s;
    logic busy, done, busy_s, done_s;

    int n_checks  = 0;
    int n_fail    = 0;
    int en_cnt    = 0;
    int done_cnt  = 0;
    int done_s_cnt = 0;
    int exp_dones = 0;
    exp_t exp_q[$];
    exp_t exp_s_q[$];
    logic [DW-1:0] mem   [DEPTH];
    logic [DW-1:0] mem_s [S_DEPTH];

    weight_bram_reader_if #(.AW(AW),   .DW(DW)) bus   ();
    weight_bram_reader_if #(.AW(S_AW), .DW(DW)) bus_s ();

    weight_bram_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .BUSY(busy), .DONE(done), .bus(bus)
    );
    weight_bram_reader #(.DEPTH(S_DEPTH), .AW(S_AW), .DW(DW)) dut_s (
        .CLK(CLK), .RST(RST), .START(start_s), .BUSY(busy_s), .DONE(done_s), .bus(bus_s)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // BRAM models: read data registered on the falling edge
    always @(negedge CLK) begin
        if (bus.BRAM_EN)
            bus.BRAM_DO <= (int'(bus.BRAM_ADDR) < DEPTH) ? mem[bus.BRAM_ADDR] : 16'hDEAD;
        if (bus_s.BRAM_EN)
            bus_s.BRAM_DO <= (int'(bus_s.BRAM_ADDR) < S_DEPTH) ? mem_s[bus_s.BRAM_ADDR] : 16'hDEAD;
    end

    // Monitors: a handshake happens on the next rising edge when valid && ready && !RST
    always @(negedge CLK) begin
        exp_t e;
        if (bus.BRAM_EN) begin
            en_cnt++;
            check("addr_range", 32'(int'(bus.BRAM_ADDR) < DEPTH), 32'd1);
        end
        check("we_zero", 32'(bus.BRAM_WE), 32'd0);
        if (done) done_cnt++;
        if (!RST && bus.W_VALID && bus.W_READY) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(bus.W_IDX), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("w_data", 32'(bus.W_DATA), 32'(e.data));
                check("w_idx",  32'(bus.W_IDX),  32'(e.idx));
                check("w_last", 32'(bus.W_LAST), 32'(e.last));
            end
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (bus_s.BRAM_EN) check("s_addr_range", 32'(int'(bus_s.BRAM_ADDR) < S_DEPTH), 32'd1);
        if (done_s) done_s_cnt++;
        if (!RST && bus_s.W_VALID && bus_s.W_READY) begin
            if (exp_s_q.size() == 0) begin
                check("s_unexpected_word", 32'(bus_s.W_IDX), 32'hFFFF_FFFF);
            end else begin
                e = exp_s_q.pop_front();
                check("s_w_data", 32'(bus_s.W_DATA), 32'(e.data));
                check("s_w_idx",  32'(bus_s.W_IDX),  32'(e.idx));
                check("s_w_last", 32'(bus_s.W_LAST), 32'(e.last));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_seq();
        for (int k = 0; k < DEPTH; k++)
            exp_q.push_back(exp_t'{DW'(16'h0100 + k), AW'(k), (k == DEPTH - 1)});
    endtask

    task automatic start_seq();
        push_seq();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            if (rnd) bus.W_READY = 1'($urandom_range(0, 1));
            tick();
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   32'(busy),          32'd0);
        check({tag, "_done"},   32'(done),          32'd0);
        check({tag, "_en"},     32'(bus.BRAM_EN),   32'd0);
        check({tag, "_addr"},   32'(bus.BRAM_ADDR), 32'd0);
        check({tag, "_we"},     32'(bus.BRAM_WE),   32'd0);
        check({tag, "_valid"},  32'(bus.W_VALID),   32'd0);
        check({tag, "_data"},   32'(bus.W_DATA),    32'd0);
        check({tag, "_idx"},    32'(bus.W_IDX),     32'd0);
        check({tag, "_last"},   32'(bus.W_LAST),    32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < DEPTH; k++)   mem[k]   = DW'(16'h0100 + k);
        for (int k = 0; k < S_DEPTH; k++) mem_s[k] = DW'(16'h0100 + k);
        RST = 1'b1; START = 1'b0; start_s = 1'b0;
        bus.W_READY = 1'b0; bus_s.W_READY = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        check("reset_s_valid", 32'(bus_s.W_VALID), 32'd0);
        RST = 1'b0;
        tick();

        // Full rate with exact latency
        bus.W_READY = 1'b1;
        start_seq();
        check("t0_busy", 32'(busy), 32'd1);
        check("t0_en", 32'(bus.BRAM_EN), 32'd1);
        check("t0_addr", 32'(bus.BRAM_ADDR), 32'd0);
        check("t0_valid", 32'(bus.W_VALID), 32'd0);
        for (int k = 1; k <= DEPTH + 1; k++) begin
            tick();
            if (k == 1) check("t1_valid", 32'(bus.W_VALID), 32'd1);
            if (k < DEPTH) begin
                check("run_en", 32'(bus.BRAM_EN), 32'd1);
                check("run_addr", 32'(bus.BRAM_ADDR), 32'(k));
            end else if (k == DEPTH) begin
                check("drain_en", 32'(bus.BRAM_EN), 32'd0);
            end
            if (k == DEPTH + 1) begin
                check("done_at_latency", 32'(done), 32'd1);
                check("busy_drop", 32'(busy), 32'd0);
            end else begin
                check("done_early", 32'(done), 32'd0);
            end
        end
        exp_dones++;
        check("full_rate_drained", 32'(exp_q.size()), 32'd0);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);

        // Stall for 10 cycles after START
        bus.W_READY = 1'b0;
        en_cnt = 0;
        start_seq();
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("stall_en", 32'(bus.BRAM_EN), (c == 1) ? 32'd1 : 32'd0);
            check("stall_valid", 32'(bus.W_VALID), 32'd1);
            check("stall_data", 32'(bus.W_DATA), 32'h0100);
            check("stall_idx", 32'(bus.W_IDX), 32'd0);
        end
        check("stall_reads", 32'(en_cnt), 32'd2);
        bus.W_READY = 1'b1;
        tick();
        check("resume_en", 32'(bus.BRAM_EN), 32'd1);
        check("resume_head", 32'(bus.W_DATA), 32'h0101);
        wait_done(100, 1'b0);
        exp_dones++;
        check("stall_total_reads", 32'(en_cnt), 32'(DEPTH));
        check("stall_drained", 32'(exp_q.size()), 32'd0);

        // Random backpressure, five back-to-back sequences
        for (int s = 0; s < 5; s++) begin
            start_seq();
            wait_done(400, 1'b1);
            exp_dones++;
            check("rand_drained", 32'(exp_q.size()), 32'd0);
        end

        // START while busy and on the completing edge is ignored
        bus.W_READY = 1'b1;
        tick();
        start_seq();
        repeat (4) tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        check("busy_after_ignored_start", 32'(busy), 32'd1);
        repeat (23) tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        check("done_with_start", 32'(done), 32'd1);
        check("start_on_done_ignored", 32'(busy), 32'd0);
        exp_dones++;
        start_seq();
        check("start_after_done", 32'(busy), 32'd1);
        wait_done(100, 1'b0);
        exp_dones++;
        tick();
        check("idle_after_restart", 32'(busy), 32'd0);

        // Reset around word 12 with toggling ready
        start_seq();
        for (int c = 0; c < 300 && exp_q.size() > DEPTH - 12; c++) begin
            bus.W_READY = ~bus.W_READY;
            tick();
        end
        check("reached_word12", 32'(exp_q.size() <= DEPTH - 12), 32'd1);
        RST = 1'b1;
        tick();
        check_reset_outputs("midreset");
        RST = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 5; c++) begin
            bus.W_READY = ~bus.W_READY;
            tick();
            check("post_reset_valid", 32'(bus.W_VALID), 32'd0);
            check("post_reset_en", 32'(bus.BRAM_EN), 32'd0);
        end
        bus.W_READY = 1'b1;
        start_seq();
        wait_done(100, 1'b0);
        exp_dones++;
        check("restart_drained", 32'(exp_q.size()), 32'd0);

        // Small instance: DEPTH=5, AW=3
        bus_s.W_READY = 1'b1;
        for (int k = 0; k < S_DEPTH; k++)
            exp_s_q.push_back(exp_t'{DW'(16'h0100 + k), AW'(k), (k == S_DEPTH - 1)});
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        check("s_busy", 32'(busy_s), 32'd1);
        for (int k = 1; k <= S_DEPTH + 1; k++) begin
            tick();
            check("s_done_timing", 32'(done_s), (k == S_DEPTH + 1) ? 32'd1 : 32'd0);
        end
        check("s_busy_drop", 32'(busy_s), 32'd0);
        check("s_drained", 32'(exp_s_q.size()), 32'd0);

        repeat (2) tick();
        check("done_count", 32'(done_cnt), 32'(exp_dones));
        check("s_done_count", 32'(done_s_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
